// File: rtl/six_bit_accumulator_if.sv
// Operand-in / result-out handshake bundle for six_bit_accumulator.
interface six_bit_accumulator_if;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] sum;
    logic [2:0] ovf_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sum, ovf_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sum, ovf_cnt
    );
endinterface

// File: rtl/six_bit_accumulator.sv
// Sums NUM_OPS 6-bit operands per result and counts carry-outs (saturating at 7).
// Optional feature: SIX_BIT_ACC_SATURATE_EN pins acc at 6'h3F after any carry-out.
module six_bit_adder (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       cin,
    output logic [5:0] s,
    output logic       cout
);
    assign {cout, s} = 7'(a) + 7'(b) + 7'(cin);
endmodule

module six_bit_accumulator #(
    parameter int unsigned NUM_OPS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    six_bit_accumulator_if.slave  bus
);
    localparam int unsigned DATA_W = 6;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned OVF_W  = 3;
    localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    typedef enum logic {ACC, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    op_cnt_q, op_cnt_d;
    logic [OVF_W-1:0]    ovf_cnt_q, ovf_cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;

    logic [DATA_W-1:0]   add_sum;
    logic                add_carry;

    six_bit_adder u_adder (
        .a    (acc_q),
        .b    (bus.in_data),
        .cin  (1'b0),
        .s    (add_sum),
        .cout (add_carry)
    );

    // State register; reset wins over any transfer or consume on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            acc_q       <= '0;
            op_cnt_q    <= '0;
            ovf_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_cnt_q    <= op_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: accumulate in ACC, present and wait for consumer in HOLD.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_cnt_d    = op_cnt_q;
        ovf_cnt_d   = ovf_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            ACC: begin
                if (bus.in_valid) begin
`ifdef SIX_BIT_ACC_SATURATE_EN
                    acc_d = add_carry ? DATA_W'(6'h3F) : add_sum;
`else
                    acc_d = add_sum;
`endif
                    op_cnt_d  = op_cnt_q + CNT_W'(1);
                    ovf_cnt_d = (add_carry && (ovf_cnt_q != OVF_MAX))
                                ? ovf_cnt_q + OVF_W'(1) : ovf_cnt_q;
                    if (op_cnt_q == LAST_OP) begin
                        state_d     = HOLD;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d     = ACC;
                    acc_d       = '0;
                    op_cnt_d    = '0;
                    ovf_cnt_d   = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = acc_q;
    assign bus.ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_six_bit_accumulator.sv
// Three accumulators (NUM_OPS = 4, 8, 1) driven together against an operand-list reference model.
module tb_six_bit_accumulator;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       iv   [3];
    logic [5:0] din  [3];
    logic       ordy [3];
    logic       ir_o [3];
    logic       ov_o [3];
    logic [5:0] sum_o[3];
    logic [2:0] ovf_o[3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        six_bit_accumulator_if bus ();
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = din[g];
        assign bus.out_ready = ordy[g];
        assign ir_o[g]  = bus.in_ready;
        assign ov_o[g]  = bus.out_valid;
        assign sum_o[g] = bus.sum;
        assign ovf_o[g] = bus.ovf_cnt;
        six_bit_accumulator #(.NUM_OPS((g == 0) ? 4 : (g == 1) ? 8 : 1)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    int vectors = 0;
    int miscompares = 0;

    // Reference: list of accepted operands for the result being built, plus phase.
    int  m_ops [3][8];
    int  m_cnt [3];
    bit  m_hold[3];

    function automatic int nops(int g);
        return (g == 0) ? 4 : (g == 1) ? 8 : 1;
    endfunction

    function automatic int ref_sum(int g);
        int a = 0;
        for (int i = 0; i < m_cnt[g]; i++) begin
`ifdef SIX_BIT_ACC_SATURATE_EN
            a = (a + m_ops[g][i] > 63) ? 63 : a + m_ops[g][i];
`else
            a = (a + m_ops[g][i]) % 64;
`endif
        end
        return a;
    endfunction

    function automatic int ref_ovf(int g);
        int a = 0;
        int c = 0;
        for (int i = 0; i < m_cnt[g]; i++) begin
            if (a + m_ops[g][i] > 63) begin
                c++;
`ifdef SIX_BIT_ACC_SATURATE_EN
                a = 63;
`else
                a = a + m_ops[g][i] - 64;
`endif
            end else begin
                a = a + m_ops[g][i];
            end
        end
        return (c > 7) ? 7 : c;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_all();
        rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b0; din[g] = 6'd0; ordy[g] = 1'b1;
        end
    endtask

    // Checks every DUT against the model, applies one edge, returns at the negedge.
    task automatic cycle();
        for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("d%0d_in_ready", g),  int'(ir_o[g]),  int'(!m_hold[g]));
            check_eq($sformatf("d%0d_out_valid", g), int'(ov_o[g]),  int'(m_hold[g]));
            check_eq($sformatf("d%0d_sum", g),       int'(sum_o[g]), ref_sum(g));
            check_eq($sformatf("d%0d_ovf_cnt", g),   int'(ovf_o[g]), ref_ovf(g));
            if (rst) begin
                m_cnt[g] = 0; m_hold[g] = 1'b0;
            end else if (!m_hold[g] && iv[g]) begin
                m_ops[g][m_cnt[g]] = int'(din[g]);
                m_cnt[g]++;
                if (m_cnt[g] == nops(g)) m_hold[g] = 1'b1;
            end else if (m_hold[g] && ordy[g]) begin
                m_cnt[g] = 0; m_hold[g] = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic feed(input int g, input int op);
        iv[g] = 1'b1; din[g] = 6'(op);
        cycle();
        iv[g] = 1'b0;
    endtask

`ifdef SIX_BIT_ACC_SATURATE_EN
    localparam int EXP28 = 63;
    localparam int EXP30 = 63;
`else
    localparam int EXP28 = 1;
    localparam int EXP30 = 56;
`endif

    initial begin
        idle_all();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            m_cnt[g] = 0; m_hold[g] = 1'b0;
        end
        rst = 1'b0;
        check_eq("reset_in_ready", int'(ir_o[0]), 1);
        check_eq("reset_sum", int'(sum_o[0]), 0);

        // 10,20,30,5 back-to-back
        feed(0, 10); feed(0, 20); feed(0, 30); feed(0, 5);
        check_eq("r28_sum", int'(sum_o[0]), EXP28);
        check_eq("r28_ovf", int'(ovf_o[0]), 1);
        check_eq("r28_valid", int'(ov_o[0]), 1);
        cycle();
        check_eq("r28_valid_one_cycle", int'(ov_o[0]), 0);

        // 1,2,3,4 with gaps, consumer stalls for 3 cycles
        ordy[0] = 1'b0;
        feed(0, 1); cycle(); feed(0, 2); cycle(); feed(0, 3); cycle(); feed(0, 4);
        for (int i = 0; i < 3; i++) begin
            check_eq("r29_sum_stable", int'(sum_o[0]), 10);
            check_eq("r29_in_ready_low", int'(ir_o[0]), 0);
            cycle();
        end
        ordy[0] = 1'b1;
        cycle();
        check_eq("r29_consumed", int'(ov_o[0]), 0);
        check_eq("r29_in_ready_back", int'(ir_o[0]), 1);

        // eight 63s on the NUM_OPS=8 instance
        for (int i = 0; i < 8; i++) feed(1, 63);
        check_eq("r30_sum", int'(sum_o[1]), EXP30);
        check_eq("r30_ovf", int'(ovf_o[1]), 7);
        cycle();

        // reset mid-accumulation
        feed(0, 7); feed(0, 9);
        rst = 1'b1; cycle(); rst = 1'b0;
        check_eq("r31_after_rst", int'(sum_o[0]), 0);
        feed(0, 4); feed(0, 4); feed(0, 4); feed(0, 4);
        check_eq("r31_sum", int'(sum_o[0]), 16);
        check_eq("r31_ovf", int'(ovf_o[0]), 0);
        cycle();

        // operand held through HOLD is not consumed until ACC
        ordy[0] = 1'b0;
        feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
        iv[0] = 1'b1; din[0] = 6'd9;
        for (int i = 0; i < 3; i++) begin
            check_eq("r32_hold_sum", int'(sum_o[0]), 4);
            cycle();
        end
        ordy[0] = 1'b1;
        cycle();
        check_eq("r32_ready_back", int'(ir_o[0]), 1);
        cycle();
        iv[0] = 1'b0;
        check_eq("r32_first_op", int'(sum_o[0]), 9);
        feed(0, 0); feed(0, 0); feed(0, 0);
        cycle();

        // NUM_OPS=1: 7 then 62
        iv[2] = 1'b1; din[2] = 6'd7;
        cycle();
        check_eq("r33_first", int'(sum_o[2]), 7);
        check_eq("r33_first_ovf", int'(ovf_o[2]), 0);
        din[2] = 6'd62;
        cycle();
        cycle();
        iv[2] = 1'b0;
        check_eq("r33_second", int'(sum_o[2]), 62);
        check_eq("r33_second_ovf", int'(ovf_o[2]), 0);
        cycle();

        // random traffic on all instances
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            for (int g = 0; g < 3; g++) begin
                iv[g]   = ($urandom_range(0, 3) != 0);
                din[g]  = 6'($urandom_range(0, 63));
                ordy[g] = ($urandom_range(0, 2) != 0);
            end
            cycle();
        end
        idle_all();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
